// File: rtl/mac_if_pkg.sv
// Shared MAC interface definitions: default widths, NIC pipe word layout and
// the Rx framing FSM encoding.
package mac_if_pkg;

  localparam int MAC_WIDTH   = 64;
  localparam int TKEEP_WIDTH = MAC_WIDTH / 8;
  localparam int NIC_WIDTH   = MAC_WIDTH + TKEEP_WIDTH + 1;

  // NIC pipe word: {last, data, keep}
  localparam int NIC_LAST_BIT = NIC_WIDTH - 1;
  localparam int NIC_DATA_HI  = NIC_WIDTH - 2;
  localparam int NIC_DATA_LO  = TKEEP_WIDTH;
  localparam int NIC_KEEP_HI  = TKEEP_WIDTH - 1;
  localparam int NIC_KEEP_LO  = 0;

  typedef enum logic [1:0] {
    RX_SYNC = 2'd0,
    RX_IDLE = 2'd1,
    RX_RECV = 2'd2,
    RX_DROP = 2'd3
  } rx_state_e;

endpackage

// File: rtl/mac_rx_frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// The read register only updates when re_i is set, so it doubles as a
// holding stage while the output register downstream is busy.
module mac_rx_frame_ram #(
  parameter int AW = 9,
  parameter int DW = 73
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  // write port
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // registered read port, holds its value when not enabled
  always_ff @(posedge clk) begin
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/mac_rx_interface.sv
// MAC Rx AXI-stream to NIC RX_FIFO pipe. Whole frames are buffered and only
// committed once a good tlast arrives; bad or overflowing frames are rewound.
module mac_rx_interface #(
  parameter int MAC_WIDTH   = mac_if_pkg::MAC_WIDTH,
  parameter int TKEEP_WIDTH = MAC_WIDTH / 8,
  parameter int NIC_WIDTH   = MAC_WIDTH + TKEEP_WIDTH + 1,
  parameter int DEPTH_LOG2  = 9,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   rx_axis_resetn,
  input  logic [MAC_WIDTH-1:0]   rx_axis_tdata,
  input  logic [TKEEP_WIDTH-1:0] rx_axis_tkeep,
  input  logic                   rx_axis_tvalid,
  input  logic                   rx_axis_tlast,
  input  logic                   rx_axis_tuser,
  output logic [NIC_WIDTH-1:0]   RX_FIFO_pipe_read_data,
  input  logic                   RX_FIFO_pipe_read_req,
  output logic                   RX_FIFO_pipe_read_ack,
  output logic [CNT_WIDTH-1:0]   rx_frames_ok,
  output logic [CNT_WIDTH-1:0]   rx_frames_dropped
);

  import mac_if_pkg::*;

  // One extra pointer bit distinguishes full from empty.
  localparam int PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

  rx_state_e            state_q, state_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        frame_start_q, frame_start_d;
  logic [PW-1:0]        commit_ptr_q, commit_ptr_d;
  // rd_ptr frees space when the NIC takes a word; fch_ptr is the RAM fetch
  // address, which runs up to two words ahead of rd_ptr.
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        fch_ptr_q, fch_ptr_d;
  logic                 ram_vld_q, ram_vld_d;
  logic                 out_vld_q, out_vld_d;
  logic [NIC_WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0] ok_cnt_q, ok_cnt_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                 resetn_q;

  logic                 fifo_full;
  logic [PW-1:0]        start_ptr;
  logic                 ram_we;
  logic [NIC_WIDTH-1:0] ram_wdata;
  logic [NIC_WIDTH-1:0] ram_rdata;
  logic                 pop, move, avail, fetch;

  assign fifo_full = (wr_ptr_q - rd_ptr_q) == FULL_LVL;
  assign ram_wdata = {rx_axis_tlast, rx_axis_tdata, rx_axis_tkeep};

  // Rx framing: write beats, commit good frames, rewind bad/overflowed ones
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    frame_start_d = frame_start_q;
    commit_ptr_d  = commit_ptr_q;
    ok_cnt_d      = ok_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    ram_we        = 1'b0;
    start_ptr     = frame_start_q;
    if (rx_axis_tvalid) begin
      case (state_q)
        RX_SYNC: begin
          if (rx_axis_tlast) state_d = RX_IDLE;
        end
        RX_IDLE, RX_RECV: begin
          start_ptr     = (state_q == RX_IDLE) ? wr_ptr_q : frame_start_q;
          frame_start_d = start_ptr;
          if (!fifo_full) begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            state_d  = RX_RECV;
            if (rx_axis_tlast) begin
              state_d = RX_IDLE;
              if (rx_axis_tuser) begin
                commit_ptr_d = wr_ptr_q + 1'b1;
                ok_cnt_d     = ok_cnt_q + 1'b1;
              end else begin
                wr_ptr_d   = start_ptr;
                drop_cnt_d = drop_cnt_q + 1'b1;
              end
            end
          end else begin
            wr_ptr_d = start_ptr;
            if (rx_axis_tlast) begin
              drop_cnt_d = drop_cnt_q + 1'b1;
              state_d    = RX_IDLE;
            end else begin
              state_d = RX_DROP;
            end
          end
        end
        RX_DROP: begin
          if (rx_axis_tlast) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
            state_d    = RX_IDLE;
          end
        end
        default: state_d = RX_SYNC;
      endcase
    end
  end

  // Read side: RAM read register feeds a show-ahead output register
  always_comb begin
    pop        = RX_FIFO_pipe_read_req && out_vld_q;
    move       = ram_vld_q && (!out_vld_q || pop);
    avail      = fch_ptr_q != commit_ptr_q;
    fetch      = avail && (!ram_vld_q || move);
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    fch_ptr_d  = fetch ? fch_ptr_q + 1'b1 : fch_ptr_q;
    ram_vld_d  = fetch ? 1'b1 : (move ? 1'b0 : ram_vld_q);
    out_vld_d  = move ? 1'b1 : (pop ? 1'b0 : out_vld_q);
    out_data_d = move ? ram_rdata : out_data_q;
  end

  // State, pointers, output stage and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RX_SYNC;
      wr_ptr_q      <= '0;
      frame_start_q <= '0;
      commit_ptr_q  <= '0;
      rd_ptr_q      <= '0;
      fch_ptr_q     <= '0;
      ram_vld_q     <= 1'b0;
      out_vld_q     <= 1'b0;
      out_data_q    <= '0;
      ok_cnt_q      <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      frame_start_q <= frame_start_d;
      commit_ptr_q  <= commit_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fch_ptr_q     <= fch_ptr_d;
      ram_vld_q     <= ram_vld_d;
      out_vld_q     <= out_vld_d;
      out_data_q    <= out_data_d;
      ok_cnt_q      <= ok_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // MAC Rx reset follows ours, released on the first edge after deassertion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) resetn_q <= 1'b0;
    else       resetn_q <= 1'b1;
  end

  mac_rx_frame_ram #(
    .AW (DEPTH_LOG2),
    .DW (NIC_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
    .wdata_i (ram_wdata),
    .re_i    (fetch),
    .raddr_i (fch_ptr_q[DEPTH_LOG2-1:0]),
    .rdata_o (ram_rdata)
  );

  assign rx_axis_resetn         = resetn_q;
  assign RX_FIFO_pipe_read_data = out_data_q;
  assign RX_FIFO_pipe_read_ack  = out_vld_q;
  assign rx_frames_ok           = ok_cnt_q;
  assign rx_frames_dropped      = drop_cnt_q;

endmodule

// File: tb/tb_mac_rx_interface.sv
// Bench for mac_rx_interface: a frame-level reference model (queue of
// committed words plus the frame in progress) predicts every word, the
// occupancy-based drop decision and both status counters.
module tb_mac_rx_interface;

  localparam int MW = 64, KW = 8, NW = 73, DL = 4, CW = 16;
  localparam int DEPTH = 2**DL;

  logic          clk = 1'b0;
  logic          reset;
  logic          resetn;
  logic [MW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          tvalid, tlast, tuser;
  logic [NW-1:0] rd;
  logic          req, ack;
  logic [CW-1:0] ok_cnt, drop_cnt;

  always #5 clk = ~clk;

  mac_rx_interface #(
    .MAC_WIDTH(MW), .TKEEP_WIDTH(KW), .NIC_WIDTH(NW), .DEPTH_LOG2(DL), .CNT_WIDTH(CW)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .rx_axis_resetn         (resetn),
    .rx_axis_tdata          (tdata),
    .rx_axis_tkeep          (tkeep),
    .rx_axis_tvalid         (tvalid),
    .rx_axis_tlast          (tlast),
    .rx_axis_tuser          (tuser),
    .RX_FIFO_pipe_read_data (rd),
    .RX_FIFO_pipe_read_req  (req),
    .RX_FIFO_pipe_read_ack  (ack),
    .rx_frames_ok           (ok_cnt),
    .rx_frames_dropped      (drop_cnt)
  );

  // reference model
  logic [NW-1:0] exp_q[$];
  logic [NW-1:0] cur_q[$];
  bit            m_sync, m_drop;
  logic [CW-1:0] m_ok, m_dropped;
  int            pops;
  bit            ack_seen;
  int            n_cmp = 0, n_err = 0;

  task automatic model_reset();
    exp_q.delete(); cur_q.delete();
    m_sync = 1'b1; m_drop = 1'b0; m_ok = '0; m_dropped = '0;
  endtask

  // One clock: drive at the negedge, score the word the NIC takes, advance the model.
  task automatic beat(input bit v, input logic [MW-1:0] d, input logic [KW-1:0] k,
                      input bit l, input bit u, input bit r);
    logic [NW-1:0] w, tmp;
    bit pop;
    tvalid = v; tdata = d; tkeep = k; tlast = l; tuser = u; req = r;
    pop = r && (ack === 1'b1);
    if (ack === 1'b1 && exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL spurious_ack: got ack=1 data=%h, required ack=0", rd);
      pop = 1'b0;
    end else if (pop) begin
      n_cmp++;
      if (rd !== exp_q[0]) begin
        n_err++; $display("FAIL rx_word: got %h, required %h", rd, exp_q[0]);
      end
    end
    w = {l, d, k};
    if (v) begin
      if (m_sync) begin
        if (l) m_sync = 1'b0;
      end else if (m_drop) begin
        if (l) begin m_drop = 1'b0; m_dropped++; end
      end else if (exp_q.size() + cur_q.size() >= DEPTH) begin
        cur_q.delete();
        if (l) m_dropped++; else m_drop = 1'b1;
      end else begin
        cur_q.push_back(w);
        if (l) begin
          if (u) begin
            foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
            m_ok++;
          end else m_dropped++;
          cur_q.delete();
        end
      end
    end
    if (pop && exp_q.size() > 0) begin tmp = exp_q.pop_front(); pops++; end
    if (ack === 1'b1) ack_seen = 1'b1;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic send_frame(input int n, input bit u, input bit r);
    for (int i = 0; i < n; i++)
      beat(1'b1, {$urandom, $urandom}, (i == n-1) ? 8'($urandom_range(1, 255)) : 8'hFF,
           i == n-1, u, r);
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      beat(1'b0, '0, '0, 1'b0, 1'b0, 1'b1); guard++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL drain_timeout: %0d words still expected, required 0", exp_q.size());
    end
    repeat (3) beat(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1; tvalid = 0; tdata = '0; tkeep = '0; tlast = 0; tuser = 0; req = 0;
    model_reset();
    repeat (2) @(negedge clk);
    n_cmp += 4;
    if (ack !== 1'b0)    begin n_err++; $display("FAIL reset_ack: got %b, required 0", ack); end
    if (rd !== '0)       begin n_err++; $display("FAIL reset_data: got %h, required 0", rd); end
    if (resetn !== 1'b0) begin n_err++; $display("FAIL reset_resetn: got %b, required 0", resetn); end
    if (ok_cnt !== '0 || drop_cnt !== '0) begin
      n_err++; $display("FAIL reset_counters: got %0d/%0d, required 0/0", ok_cnt, drop_cnt);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (resetn !== 1'b1) begin n_err++; $display("FAIL resetn_release: got %b, required 1", resetn); end
    @(negedge clk);
  endtask

  task automatic test_good_frame();
    pops = 0;
    beat(1'b1, 64'hAA, 8'hFF, 1'b0, 1'b1, 1'b0);  // partial frame after reset
    beat(1'b1, 64'hBB, 8'hFF, 1'b1, 1'b1, 1'b0);  // its end resynchronises
    beat(1'b1, 64'd1, 8'hFF, 1'b0, 1'b1, 1'b1);
    beat(1'b1, 64'd2, 8'hFF, 1'b0, 1'b1, 1'b1);
    beat(1'b1, 64'd3, 8'h0F, 1'b1, 1'b1, 1'b1);
    drain();
    n_cmp += 2;
    if (pops != 3) begin n_err++; $display("FAIL good_words: got %0d, required 3", pops); end
    if (ok_cnt !== 16'd1 || ok_cnt !== m_ok) begin
      n_err++; $display("FAIL good_ok: got %0d, required 1", ok_cnt);
    end
  endtask

  task automatic test_bad_frame();
    logic [CW-1:0] ok0, dr0;
    ok0 = ok_cnt; dr0 = drop_cnt; pops = 0;
    send_frame(4, 1'b0, 1'b1);
    send_frame(2, 1'b1, 1'b1);
    drain();
    n_cmp += 3;
    if (pops != 2) begin n_err++; $display("FAIL bad_words: got %0d, required 2", pops); end
    if (drop_cnt - dr0 !== 16'd1) begin n_err++; $display("FAIL bad_dropped: got +%0d, required +1", drop_cnt - dr0); end
    if (ok_cnt - ok0 !== 16'd1) begin n_err++; $display("FAIL bad_ok: got +%0d, required +1", ok_cnt - ok0); end
  endtask

  task automatic test_overflow();
    logic [CW-1:0] dr0;
    dr0 = drop_cnt; pops = 0;
    send_frame(10, 1'b1, 1'b0);
    send_frame(10, 1'b1, 1'b0);
    repeat (4) beat(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    drain();
    n_cmp += 3;
    if (pops != 10) begin n_err++; $display("FAIL ovf_words: got %0d, required 10", pops); end
    if (drop_cnt - dr0 !== 16'd1) begin n_err++; $display("FAIL ovf_dropped: got +%0d, required +1", drop_cnt - dr0); end
    if (drop_cnt !== m_dropped) begin n_err++; $display("FAIL ovf_model_drop: got %0d, required %0d", drop_cnt, m_dropped); end
  endtask

  task automatic test_oversize();
    logic [CW-1:0] dr0, ok0;
    dr0 = drop_cnt; ok0 = ok_cnt; ack_seen = 1'b0;
    send_frame(20, 1'b1, 1'b0);
    repeat (5) beat(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    n_cmp += 3;
    if (ack_seen) begin n_err++; $display("FAIL oversize_ack: got ack seen, required none"); end
    if (drop_cnt - dr0 !== 16'd1) begin n_err++; $display("FAIL oversize_dropped: got +%0d, required +1", drop_cnt - dr0); end
    if (ok_cnt !== ok0) begin n_err++; $display("FAIL oversize_ok: got %0d, required %0d", ok_cnt, ok0); end
  endtask

  task automatic test_back_to_back();
    bit in_frame = 1'b0; int left = 0; bit user = 1'b1;
    for (int i = 0; i < 24; i++) begin
      n_cmp++;
      if (ack !== (i >= 3)) begin
        n_err++; $display("FAIL b2b_ack[%0d]: got %b, required %b", i, ack, i >= 3);
      end
      beat(1'b1, {$urandom, $urandom}, 8'($urandom_range(1, 255)), 1'b1, 1'b1, 1'b1);
    end
    // random frames, gaps, bad frames and random req
    for (int i = 0; i < 600; i++) begin
      if (!in_frame && ($urandom_range(0, 3) != 0)) begin
        in_frame = 1'b1; left = $urandom_range(1, 12); user = ($urandom_range(0, 4) != 0);
      end
      if (in_frame && ($urandom_range(0, 3) != 0)) begin
        beat(1'b1, {$urandom, $urandom}, 8'($urandom), left == 1, user, 1'($urandom));
        left--;
        if (left == 0) in_frame = 1'b0;
      end else begin
        beat(1'b0, {$urandom, $urandom}, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end
    end
    while (in_frame) begin
      beat(1'b1, {$urandom, $urandom}, 8'hFF, left == 1, user, 1'b1);
      left--;
      if (left == 0) in_frame = 1'b0;
    end
    drain();
    n_cmp += 2;
    if (ok_cnt !== m_ok) begin n_err++; $display("FAIL rand_ok: got %0d, required %0d", ok_cnt, m_ok); end
    if (drop_cnt !== m_dropped) begin n_err++; $display("FAIL rand_dropped: got %0d, required %0d", drop_cnt, m_dropped); end
  endtask

  task automatic test_reset_mid();
    send_frame(3, 1'b1, 1'b0);
    repeat (2) beat(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    beat(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);       // one word taken, read in progress
    beat(1'b1, 64'h11, 8'hFF, 1'b0, 1'b1, 1'b0);
    beat(1'b1, 64'h12, 8'hFF, 1'b0, 1'b1, 1'b0);
    beat(1'b1, 64'h13, 8'hFF, 1'b0, 1'b1, 1'b0);
    reset = 1'b1; tvalid = 1'b0; req = 1'b0;
    #1;
    n_cmp += 3;
    if (ack !== 1'b0) begin n_err++; $display("FAIL midrst_ack: got %b, required 0", ack); end
    if (ok_cnt !== '0 || drop_cnt !== '0) begin
      n_err++; $display("FAIL midrst_counters: got %0d/%0d, required 0/0", ok_cnt, drop_cnt);
    end
    if (resetn !== 1'b0) begin n_err++; $display("FAIL midrst_resetn: got %b, required 0", resetn); end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    pops = 0;
    beat(1'b1, 64'h14, 8'hFF, 1'b0, 1'b1, 1'b1);
    beat(1'b1, 64'h15, 8'hFF, 1'b0, 1'b1, 1'b1);
    beat(1'b1, 64'h16, 8'h03, 1'b1, 1'b1, 1'b1);
    send_frame(4, 1'b1, 1'b1);
    drain();
    n_cmp += 3;
    if (pops != 4) begin n_err++; $display("FAIL midrst_words: got %0d, required 4", pops); end
    if (ok_cnt !== 16'd1) begin n_err++; $display("FAIL midrst_ok: got %0d, required 1", ok_cnt); end
    if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL midrst_dropped: got %0d, required 0", drop_cnt); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_frame();
    test_overflow();
    test_oversize();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
